// File: rtl/rs_wakeup_req.sv
// rtl/rs_wakeup_req.sv - reservation-station wakeup and issue-request tracker
module rs_wakeup_req #(
    parameter int N_ENT = 8,
    parameter int TAG_W = 5
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [1:0]                  alloc_valid,
    input  logic [1:0][2:0]             alloc_entry,
    input  logic [1:0][1:0][TAG_W-1:0]  alloc_tag,
    input  logic [1:0][1:0]             alloc_rdy,
    input  logic [1:0]                  cdb_valid,
    input  logic [1:0][TAG_W-1:0]       cdb_tag,
    input  logic [N_ENT-1:0]            gnt,
    input  logic                        flush,
    output logic [N_ENT-1:0]            req,
    output logic [2:0]                  cnt,
    output logic [N_ENT-1:0]            busy,
    output logic [3:0]                  free_cnt,
    output logic                        alloc_err
);

    logic [N_ENT-1:0][1:0]            rdy_q;
    logic [N_ENT-1:0][1:0]            rdy_d;
    logic [N_ENT-1:0][1:0][TAG_W-1:0] tag_q;
    logic [N_ENT-1:0][1:0][TAG_W-1:0] tag_d;
    logic [N_ENT-1:0]                 busy_d;
    logic [N_ENT-1:0]                 fire;
    logic [1:0]                       slot_ok;
    logic                             err_d;

    // True when either valid broadcast carries tag t.
    function automatic logic cdb_hit(
        input logic [1:0]            v,
        input logic [1:0][TAG_W-1:0] ct,
        input logic [TAG_W-1:0]      t
    );
        return (v[0] && (ct[0] == t)) || (v[1] && (ct[1] == t));
    endfunction

    // Issue requests come only from registered state, so the selector sees no input-to-req path.
    always_comb begin
        req = '0;
        for (int i = 0; i < N_ENT; i++) begin
            req[i] = busy[i] & rdy_q[i][0] & rdy_q[i][1];
        end
    end

    assign fire = gnt & req;

    // Slot acceptance: an entry can take a new instruction if free or being issued this cycle;
    // slot 1 loses to slot 0 when both name the same entry.
    always_comb begin
        slot_ok    = '0;
        slot_ok[0] = alloc_valid[0] & (~busy[alloc_entry[0]] | fire[alloc_entry[0]]);
        slot_ok[1] = alloc_valid[1]
                   & ~(alloc_valid[0] & (alloc_entry[1] == alloc_entry[0]))
                   & (~busy[alloc_entry[1]] | fire[alloc_entry[1]]);
        err_d      = (alloc_valid[0] & ~slot_ok[0]) | (alloc_valid[1] & ~slot_ok[1]);
    end

    // Per-entry next state: wakeup, then issue clear, then allocation (which wins), then flush.
    always_comb begin
        busy_d = busy;
        rdy_d  = rdy_q;
        tag_d  = tag_q;
        for (int i = 0; i < N_ENT; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (busy[i] && cdb_hit(cdb_valid, cdb_tag, tag_q[i][k])) begin
                    rdy_d[i][k] = 1'b1;
                end
            end
            if (fire[i]) begin
                busy_d[i] = 1'b0;
                rdy_d[i]  = '0;
            end
            if (slot_ok[0] && (alloc_entry[0] == 3'(i))) begin
                busy_d[i] = 1'b1;
                tag_d[i]  = alloc_tag[0];
                for (int k = 0; k < 2; k++) begin
                    rdy_d[i][k] = alloc_rdy[0][k] | cdb_hit(cdb_valid, cdb_tag, alloc_tag[0][k]);
                end
            end else if (slot_ok[1] && (alloc_entry[1] == 3'(i))) begin
                busy_d[i] = 1'b1;
                tag_d[i]  = alloc_tag[1];
                for (int k = 0; k < 2; k++) begin
                    rdy_d[i][k] = alloc_rdy[1][k] | cdb_hit(cdb_valid, cdb_tag, alloc_tag[1][k]);
                end
            end
        end
        if (flush) begin
            busy_d = '0;
            rdy_d  = '0;
        end
    end

    // Free-entry population count from registered occupancy.
    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < N_ENT; i++) begin
            if (!busy[i]) begin
                free_cnt = free_cnt + 4'd1;
            end
        end
    end

    // State registers; the rotating pointer advances once per edge with any issue.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy      <= '0;
            rdy_q     <= '0;
            tag_q     <= '0;
            cnt       <= '0;
            alloc_err <= 1'b0;
        end else begin
            busy      <= busy_d;
            rdy_q     <= rdy_d;
            tag_q     <= tag_d;
            alloc_err <= err_d & ~flush;
            if (|fire) begin
                cnt <= cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_rs_wakeup_req.sv
// tb/tb_rs_wakeup_req.sv - scoreboard bench for rs_wakeup_req
module tb_rs_wakeup_req;

    localparam int TAG_W = 5;

    logic                        clock = 1'b0;
    logic                        reset = 1'b0;
    logic [1:0]                  alloc_valid;
    logic [1:0][2:0]             alloc_entry;
    logic [1:0][1:0][TAG_W-1:0]  alloc_tag;
    logic [1:0][1:0]             alloc_rdy;
    logic [1:0]                  cdb_valid;
    logic [1:0][TAG_W-1:0]       cdb_tag;
    logic [7:0]                  gnt;
    logic                        flush;
    logic [7:0]                  req;
    logic [2:0]                  cnt;
    logic [7:0]                  busy;
    logic [3:0]                  free_cnt;
    logic                        alloc_err;

    logic [23:0] sb[$];
    logic [23:0] got;
    logic [23:0] exp_v;
    int          vectors = 0;
    int          misses  = 0;

    rs_wakeup_req #(.N_ENT(8), .TAG_W(TAG_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .alloc_valid(alloc_valid),
        .alloc_entry(alloc_entry),
        .alloc_tag  (alloc_tag),
        .alloc_rdy  (alloc_rdy),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .gnt        (gnt),
        .flush      (flush),
        .req        (req),
        .cnt        (cnt),
        .busy       (busy),
        .free_cnt   (free_cnt),
        .alloc_err  (alloc_err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    function automatic logic [23:0] pk(input logic [7:0] r, input logic [7:0] b,
                                       input logic [2:0] c, input logic [3:0] f, input logic e);
        return {r, b, c, f, e};
    endfunction

    task automatic idle();
        alloc_valid = '0;
        alloc_entry = '0;
        alloc_tag   = '0;
        alloc_rdy   = '0;
        cdb_valid   = '0;
        cdb_tag     = '0;
        gnt         = '0;
        flush       = 1'b0;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            idle();
            if (c == 1) begin
                alloc_valid = 2'b01; alloc_entry[0] = 3'd0; alloc_rdy[0] = 2'b11;
            end
            sb.push_back(pk(8'h00, 8'h00, 3'd0, 4'd8, 1'b0));
            @(posedge clock); #1;
            got = {req, busy, cnt, free_cnt, alloc_err};
            vectors++;
            if (sb.size() == 0) begin
                misses++; $display("FAIL test_reset cycle %0d: scoreboard empty", c);
            end else begin
                exp_v = sb.pop_front();
                if (got !== exp_v) begin
                    misses++;
                    $display("FAIL test_reset cycle %0d: req/busy/cnt/free/err got %h expected %h", c, got, exp_v);
                end
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_alloc_ready();
        for (int c = 0; c < 2; c++) begin
            idle();
            case (c)
                0: begin
                    alloc_valid = 2'b01; alloc_entry[0] = 3'd3;
                    alloc_tag[0][0] = 5'd1; alloc_tag[0][1] = 5'd2; alloc_rdy[0] = 2'b11;
                    sb.push_back(pk(8'h08, 8'h08, 3'd0, 4'd7, 1'b0));
                end
                default: begin
                    gnt = 8'h08;
                    sb.push_back(pk(8'h00, 8'h00, 3'd1, 4'd8, 1'b0));
                end
            endcase
            @(posedge clock); #1;
            got = {req, busy, cnt, free_cnt, alloc_err};
            vectors++;
            if (sb.size() == 0) begin
                misses++; $display("FAIL test_alloc_ready cycle %0d: scoreboard empty", c);
            end else begin
                exp_v = sb.pop_front();
                if (got !== exp_v) begin
                    misses++;
                    $display("FAIL test_alloc_ready cycle %0d: req/busy/cnt/free/err got %h expected %h", c, got, exp_v);
                end
            end
        end
    endtask

    task automatic test_dual_cdb();
        for (int c = 0; c < 4; c++) begin
            idle();
            case (c)
                0: begin
                    alloc_valid = 2'b01; alloc_entry[0] = 3'd5;
                    alloc_tag[0][0] = 5'd4; alloc_tag[0][1] = 5'd9;
                    sb.push_back(pk(8'h00, 8'h20, 3'd1, 4'd7, 1'b0));
                end
                1: begin
                    cdb_tag[0] = 5'd4; cdb_tag[1] = 5'd9;
                    sb.push_back(pk(8'h00, 8'h20, 3'd1, 4'd7, 1'b0));
                end
                2: begin
                    cdb_valid = 2'b11; cdb_tag[0] = 5'd4; cdb_tag[1] = 5'd9;
                    sb.push_back(pk(8'h20, 8'h20, 3'd1, 4'd7, 1'b0));
                end
                default: begin
                    gnt = 8'h20;
                    sb.push_back(pk(8'h00, 8'h00, 3'd2, 4'd8, 1'b0));
                end
            endcase
            @(posedge clock); #1;
            got = {req, busy, cnt, free_cnt, alloc_err};
            vectors++;
            if (sb.size() == 0) begin
                misses++; $display("FAIL test_dual_cdb cycle %0d: scoreboard empty", c);
            end else begin
                exp_v = sb.pop_front();
                if (got !== exp_v) begin
                    misses++;
                    $display("FAIL test_dual_cdb cycle %0d: req/busy/cnt/free/err got %h expected %h", c, got, exp_v);
                end
            end
        end
    endtask

    task automatic test_bypass();
        for (int c = 0; c < 3; c++) begin
            idle();
            case (c)
                0: begin
                    alloc_valid = 2'b11;
                    alloc_entry[0] = 3'd6; alloc_tag[0][0] = 5'd10; alloc_tag[0][1] = 5'd11;
                    alloc_entry[1] = 3'd2; alloc_tag[1][0] = 5'd7;  alloc_tag[1][1] = 5'd3;
                    alloc_rdy[1] = 2'b10;
                    cdb_valid = 2'b11; cdb_tag[0] = 5'd7; cdb_tag[1] = 5'd11;
                    sb.push_back(pk(8'h04, 8'h44, 3'd2, 4'd6, 1'b0));
                end
                1: begin
                    gnt = 8'h40; cdb_valid = 2'b10; cdb_tag[1] = 5'd10;
                    sb.push_back(pk(8'h44, 8'h44, 3'd2, 4'd6, 1'b0));
                end
                default: begin
                    gnt = 8'h44;
                    sb.push_back(pk(8'h00, 8'h00, 3'd3, 4'd8, 1'b0));
                end
            endcase
            @(posedge clock); #1;
            got = {req, busy, cnt, free_cnt, alloc_err};
            vectors++;
            if (sb.size() == 0) begin
                misses++; $display("FAIL test_bypass cycle %0d: scoreboard empty", c);
            end else begin
                exp_v = sb.pop_front();
                if (got !== exp_v) begin
                    misses++;
                    $display("FAIL test_bypass cycle %0d: req/busy/cnt/free/err got %h expected %h", c, got, exp_v);
                end
            end
        end
    endtask

    task automatic test_alloc_err();
        for (int c = 0; c < 8; c++) begin
            idle();
            case (c)
                0: begin
                    alloc_valid = 2'b01; alloc_entry[0] = 3'd0;
                    alloc_tag[0][0] = 5'd1; alloc_tag[0][1] = 5'd1;
                    sb.push_back(pk(8'h00, 8'h01, 3'd3, 4'd7, 1'b0));
                end
                1: begin
                    alloc_valid = 2'b01; alloc_entry[0] = 3'd0;
                    alloc_tag[0][0] = 5'd2; alloc_tag[0][1] = 5'd2; alloc_rdy[0] = 2'b11;
                    sb.push_back(pk(8'h00, 8'h01, 3'd3, 4'd7, 1'b1));
                end
                2: sb.push_back(pk(8'h00, 8'h01, 3'd3, 4'd7, 1'b0));
                3: begin
                    cdb_valid = 2'b01; cdb_tag[0] = 5'd1;
                    sb.push_back(pk(8'h01, 8'h01, 3'd3, 4'd7, 1'b0));
                end
                4: begin
                    gnt = 8'h01;
                    alloc_valid = 2'b01; alloc_entry[0] = 3'd0;
                    alloc_tag[0][0] = 5'd5; alloc_tag[0][1] = 5'd6;
                    sb.push_back(pk(8'h00, 8'h01, 3'd4, 4'd7, 1'b0));
                end
                5: begin
                    cdb_valid = 2'b01; cdb_tag[0] = 5'd1;
                    sb.push_back(pk(8'h00, 8'h01, 3'd4, 4'd7, 1'b0));
                end
                6: begin
                    cdb_valid = 2'b11; cdb_tag[0] = 5'd5; cdb_tag[1] = 5'd6;
                    sb.push_back(pk(8'h01, 8'h01, 3'd4, 4'd7, 1'b0));
                end
                default: begin
                    gnt = 8'h01;
                    sb.push_back(pk(8'h00, 8'h00, 3'd5, 4'd8, 1'b0));
                end
            endcase
            @(posedge clock); #1;
            got = {req, busy, cnt, free_cnt, alloc_err};
            vectors++;
            if (sb.size() == 0) begin
                misses++; $display("FAIL test_alloc_err cycle %0d: scoreboard empty", c);
            end else begin
                exp_v = sb.pop_front();
                if (got !== exp_v) begin
                    misses++;
                    $display("FAIL test_alloc_err cycle %0d: req/busy/cnt/free/err got %h expected %h", c, got, exp_v);
                end
            end
        end
    endtask

    task automatic test_collision();
        for (int c = 0; c < 3; c++) begin
            idle();
            case (c)
                0: begin
                    alloc_valid = 2'b11;
                    alloc_entry[0] = 3'd4; alloc_tag[0][0] = 5'd12; alloc_tag[0][1] = 5'd13;
                    alloc_entry[1] = 3'd4; alloc_tag[1][0] = 5'd14; alloc_tag[1][1] = 5'd15;
                    alloc_rdy[1] = 2'b11;
                    sb.push_back(pk(8'h00, 8'h10, 3'd5, 4'd7, 1'b1));
                end
                1: begin
                    cdb_valid = 2'b11; cdb_tag[0] = 5'd14; cdb_tag[1] = 5'd15;
                    sb.push_back(pk(8'h00, 8'h10, 3'd5, 4'd7, 1'b0));
                end
                default: begin
                    cdb_valid = 2'b11; cdb_tag[0] = 5'd12; cdb_tag[1] = 5'd13;
                    sb.push_back(pk(8'h10, 8'h10, 3'd5, 4'd7, 1'b0));
                end
            endcase
            @(posedge clock); #1;
            got = {req, busy, cnt, free_cnt, alloc_err};
            vectors++;
            if (sb.size() == 0) begin
                misses++; $display("FAIL test_collision cycle %0d: scoreboard empty", c);
            end else begin
                exp_v = sb.pop_front();
                if (got !== exp_v) begin
                    misses++;
                    $display("FAIL test_collision cycle %0d: req/busy/cnt/free/err got %h expected %h", c, got, exp_v);
                end
            end
        end
    endtask

    task automatic test_wrap();
        for (int c = 0; c < 4; c++) begin
            idle();
            case (c)
                0: begin
                    alloc_valid = 2'b11;
                    alloc_entry[0] = 3'd7; alloc_rdy[0] = 2'b11;
                    alloc_entry[1] = 3'd0; alloc_rdy[1] = 2'b11;
                    sb.push_back(pk(8'h91, 8'h91, 3'd5, 4'd5, 1'b0));
                end
                1: begin
                    gnt = 8'h10;
                    alloc_valid = 2'b01; alloc_entry[0] = 3'd1; alloc_rdy[0] = 2'b11;
                    sb.push_back(pk(8'h83, 8'h83, 3'd6, 4'd5, 1'b0));
                end
                2: begin
                    gnt = 8'h02;
                    sb.push_back(pk(8'h81, 8'h81, 3'd7, 4'd6, 1'b0));
                end
                default: begin
                    gnt = 8'h80;
                    sb.push_back(pk(8'h01, 8'h01, 3'd0, 4'd7, 1'b0));
                end
            endcase
            @(posedge clock); #1;
            got = {req, busy, cnt, free_cnt, alloc_err};
            vectors++;
            if (sb.size() == 0) begin
                misses++; $display("FAIL test_wrap cycle %0d: scoreboard empty", c);
            end else begin
                exp_v = sb.pop_front();
                if (got !== exp_v) begin
                    misses++;
                    $display("FAIL test_wrap cycle %0d: req/busy/cnt/free/err got %h expected %h", c, got, exp_v);
                end
            end
        end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 2; c++) begin
            idle();
            if (c == 0) begin
                flush = 1'b1;
                alloc_valid = 2'b01; alloc_entry[0] = 3'd1; alloc_rdy[0] = 2'b11;
                cdb_valid = 2'b01; cdb_tag[0] = 5'd3;
            end
            sb.push_back(pk(8'h00, 8'h00, 3'd0, 4'd8, 1'b0));
            @(posedge clock); #1;
            got = {req, busy, cnt, free_cnt, alloc_err};
            vectors++;
            if (sb.size() == 0) begin
                misses++; $display("FAIL test_flush cycle %0d: scoreboard empty", c);
            end else begin
                exp_v = sb.pop_front();
                if (got !== exp_v) begin
                    misses++;
                    $display("FAIL test_flush cycle %0d: req/busy/cnt/free/err got %h expected %h", c, got, exp_v);
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        for (int c = 0; c < 4; c++) begin
            idle();
            case (c)
                0: begin
                    alloc_valid = 2'b11;
                    alloc_entry[0] = 3'd3; alloc_rdy[0] = 2'b11;
                    alloc_entry[1] = 3'd5; alloc_rdy[1] = 2'b11;
                    sb.push_back(pk(8'h28, 8'h28, 3'd0, 4'd6, 1'b0));
                end
                1: begin
                    gnt = 8'h08;
                    sb.push_back(pk(8'h20, 8'h20, 3'd1, 4'd7, 1'b0));
                end
                default: sb.push_back(pk(8'h00, 8'h00, 3'd0, 4'd8, 1'b0));
            endcase
            if (c == 2) begin
                reset = 1'b0;
                #2;
            end else begin
                @(posedge clock); #1;
            end
            got = {req, busy, cnt, free_cnt, alloc_err};
            vectors++;
            if (sb.size() == 0) begin
                misses++; $display("FAIL test_reset_midop cycle %0d: scoreboard empty", c);
            end else begin
                exp_v = sb.pop_front();
                if (got !== exp_v) begin
                    misses++;
                    $display("FAIL test_reset_midop cycle %0d: req/busy/cnt/free/err got %h expected %h", c, got, exp_v);
                end
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 5; c++) begin
            idle();
            case (c)
                0: begin
                    alloc_valid = 2'b01; alloc_entry[0] = 3'd2; alloc_rdy[0] = 2'b11;
                    sb.push_back(pk(8'h04, 8'h04, 3'd0, 4'd7, 1'b0));
                end
                1: begin
                    gnt = 8'h04;
                    alloc_valid = 2'b01; alloc_entry[0] = 3'd6; alloc_rdy[0] = 2'b11;
                    sb.push_back(pk(8'h40, 8'h40, 3'd1, 4'd7, 1'b0));
                end
                2: begin
                    gnt = 8'h40;
                    alloc_valid = 2'b10; alloc_entry[1] = 3'd6;
                    alloc_tag[1][1] = 5'd20; alloc_rdy[1] = 2'b01;
                    sb.push_back(pk(8'h00, 8'h40, 3'd2, 4'd7, 1'b0));
                end
                3: begin
                    cdb_valid = 2'b10; cdb_tag[1] = 5'd20;
                    sb.push_back(pk(8'h40, 8'h40, 3'd2, 4'd7, 1'b0));
                end
                default: begin
                    gnt = 8'h40;
                    sb.push_back(pk(8'h00, 8'h00, 3'd3, 4'd8, 1'b0));
                end
            endcase
            @(posedge clock); #1;
            got = {req, busy, cnt, free_cnt, alloc_err};
            vectors++;
            if (sb.size() == 0) begin
                misses++; $display("FAIL test_back_to_back cycle %0d: scoreboard empty", c);
            end else begin
                exp_v = sb.pop_front();
                if (got !== exp_v) begin
                    misses++;
                    $display("FAIL test_back_to_back cycle %0d: req/busy/cnt/free/err got %h expected %h", c, got, exp_v);
                end
            end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_alloc_ready();
        test_dual_cdb();
        test_bypass();
        test_alloc_err();
        test_collision();
        test_wrap();
        test_flush();
        test_reset_midop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule

// File: doc/rs_wakeup_req.md
RS_WAKEUP_REQ -- requirements
Module: rs_wakeup_req

Interface
REQ-001 SHALL have parameter N_ENT, default 8, the number of reservation-station entries; the only supported value is 8, matching rps8.
REQ-002 SHALL have parameter TAG_W, default 5, the width of a source-operand tag.
REQ-003 SHALL have port clock, input, 1 bit; all state updates occur on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous and active-low (state cleared while reset==0).
REQ-005 SHALL have port alloc_valid, input, [1:0]; per-slot allocate strobe (2-way dispatch).
REQ-006 SHALL have port alloc_entry, input, [1:0][2:0]; target entry index per slot.
REQ-007 SHALL have port alloc_tag, input, [1:0][1:0][TAG_W-1:0]; indexed [slot][src], the source tags.
REQ-008 SHALL have port alloc_rdy, input, [1:0][1:0]; source already available at dispatch.
REQ-009 SHALL have port cdb_valid, input, [1:0]; two completion broadcasts per cycle.
REQ-010 SHALL have port cdb_tag, input, [1:0][TAG_W-1:0]; the broadcast tags.
REQ-011 SHALL have port gnt, input, [7:0]; issue grant vector returned by the rotating selector.
REQ-012 SHALL have port flush, input, 1 bit; synchronous squash of all entries.
REQ-013 SHALL have port req, output, [7:0]; issue request vector to the selector.
REQ-014 SHALL have port cnt, output, [2:0]; rotating-priority pointer to the selector.
REQ-015 SHALL have port busy, output, [7:0]; entry-occupied mask.
REQ-016 SHALL have port free_cnt, output, [3:0]; number of entries with busy==0 (0..8).
REQ-017 SHALL have port alloc_err, output, 1 bit; registered one-cycle error pulse.

Function
REQ-018 SHALL hold per entry: busy, rdy[1:0], tag[1:0].
REQ-019 SHALL drive req[i] = busy[i] & rdy[i][0] & rdy[i][1], decoded from registered state only, with no combinational path from any input to req.
REQ-020 SHALL, on alloc_valid[s] to entry e, set busy[e]=1 and tag[e]=alloc_tag[s] at the next edge.
REQ-021 SHALL set rdy[e][k] = alloc_rdy[s][k] | (cdb_valid[j] & cdb_tag[j]==alloc_tag[s][k] for any j); this is a same-cycle wakeup bypass.
REQ-022 SHALL, for every busy entry with rdy[k]==0, set rdy[k] at the next edge when any valid cdb_tag matches tag[k]; both CDB ports are checked independently.
REQ-023 SHALL clear busy[i] and rdy[i] at the next edge when gnt[i]==1 and req[i]==1.
REQ-024 SHALL ignore gnt[i] when req[i]==0.
REQ-025 SHALL let allocation win when the same entry is granted and allocated in one cycle, so the entry holds the new instruction.
REQ-026 SHALL ignore an allocation to an entry that is busy and not granted this cycle, and pulse alloc_err.
REQ-027 SHALL honour only slot 0 when both slots target the same entry, and pulse alloc_err.
REQ-028 SHALL increment cnt modulo 8 (7 wraps to 0) on each edge where |(gnt & req)==1; otherwise cnt holds.
REQ-029 SHALL, on flush, clear all busy and rdy bits at the next edge and override same-cycle allocation and wakeup; cnt is unaffected.
REQ-030 SHALL compute free_cnt as the population count of ~busy from registered state.

Reset
REQ-031 SHALL, while reset==0, asynchronously set busy=0, rdy=0, tag=0, cnt=0 and alloc_err=0; consequently req=0 and free_cnt=8.
REQ-032 SHALL allow the first update on the first rising edge after reset deasserts; reset mid-operation discards all entries immediately.

Verification
REQ-033 SHALL cover: alloc slot0 to entry 3 with alloc_rdy=2'b11 -> next cycle req=8'h08, busy=8'h08, free_cnt=7.
REQ-034 SHALL cover: alloc entry 5 with tags {4,9}, rdy=0; cdb0=4 and cdb1=9 in the same cycle -> req[5]=1 one cycle later.
REQ-035 SHALL cover: alloc entry 2 with tag 7 and cdb_tag=7 valid in the same cycle -> rdy bypassed; req[2]=1 on the next cycle.
REQ-036 SHALL cover: req=8'h81, gnt=8'h80 with cnt=7 -> next cycle req=8'h01, cnt=0, busy[7]=0.
REQ-037 SHALL cover: both slots allocate entry 4 -> only slot0's tags stored, alloc_err=1 for exactly one cycle.
REQ-038 SHALL cover: flush with simultaneous alloc to entry 1 -> busy=0, free_cnt=8; reset low mid-cycle -> req=0 before the next edge.
